pixel_word_packer: RTL and testbench

//  Inverse of the search-window pixel unpacker: gathers a serial stream of one

---
 rtl/pixel_word_packer.sv | 191 +++++++++++++++++++
 tb/tb_pixel_word_packer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_word_packer.sv
// pixel_word_packer
//   Gathers a serial stream of one pixel per cycle into OUTPUT_WIDTH-bit words
//   for the reference-frame buffer write port. An assembly register collects
//   pixels while an output register presents the previous word, so the packer
//   keeps accepting 1 pixel/clk under valid/ready backpressure. The last word
//   of each row (ROW_WORDS words per row) is tagged with out_last.
//
//   Optional feature: define PIXEL_PACKER_FLUSH_EN to let an accepted pixel
//   with in_last=1 close the current word early (unfilled slots zero, word
//   tagged last, row counter restarts). Without it in_last is ignored.
//
// Ports
//   clk_i      clock, rising edge
//   rst_ni     synchronous reset, active low
//   in_valid   pixel valid
//   in_ready   packer accepts a pixel this cycle
//   in_pixel   pixel data (PIXEL_WIDTH)
//   in_last    last pixel of row (flush feature only)
//   out_valid  packed word valid
//   out_ready  consumer accepts word
//   out_data   packed word, first pixel in LSBs (OUTPUT_WIDTH)
//   out_last   word is the last of its row
//   state_o    debug view of the FSM state (0 = FILL, 1 = HOLD)
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; a producer holding valid keeps its payload stable until that edge.
// in_ready depends on the FSM state only, never on in_valid.

module pixel_word_packer #(
   parameter int OUTPUT_WIDTH = 128,
   parameter int PIXEL_WIDTH  = 8,
   parameter int ROW_WORDS    = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [PIXEL_WIDTH-1:0]  in_pixel,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUTPUT_WIDTH-1:0] out_data,
   output logic                    out_last,
   output logic                    state_o
);

   localparam int P     = OUTPUT_WIDTH / PIXEL_WIDTH;
   localparam int CNT_W = (P > 1) ? $clog2(P) : 1;
   localparam int ROW_W = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(P - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROW_WORDS - 1);

   typedef enum logic {
      S_FILL = 1'b0,
      S_HOLD = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [OUTPUT_WIDTH-1:0] asm_q, asm_d;
   logic                    hold_last_q, hold_last_d;
   logic [ROW_W-1:0]        row_q, row_d;
   logic                    out_valid_q, out_valid_d;
   logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
   logic                    out_last_q, out_last_d;

   logic                    accept;
   logic                    slot_free;
   logic                    flush_close;
   logic                    close_word;
   logic                    load_out;
   logic [OUTPUT_WIDTH-1:0] load_data;
   logic                    load_forced;
   logic                    row_end;
   logic [OUTPUT_WIDTH-1:0] merged;

`ifdef PIXEL_PACKER_FLUSH_EN
   assign flush_close = in_last;
`else
   logic unused_in_last;
   assign unused_in_last = in_last;
   assign flush_close    = 1'b0;
`endif

   assign in_ready  = (state_q == S_FILL);
   assign accept    = in_valid & in_ready;
   // A word draining this very cycle frees the slot for the next one.
   assign slot_free = ~out_valid_q | out_ready;
   assign close_word = (cnt_q == CNT_MAX) | flush_close;

   // Assembly contents with the incoming pixel dropped into slot cnt_q.
   always_comb begin
      merged = asm_q;
      for (int k = 0; k < P; k++) begin
         if (cnt_q == CNT_W'(k)) begin
            merged[k*PIXEL_WIDTH +: PIXEL_WIDTH] = in_pixel;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      asm_d       = asm_q;
      hold_last_d = hold_last_q;
      row_d       = row_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      load_out    = 1'b0;
      load_data   = '0;
      load_forced = 1'b0;
      row_end     = 1'b0;

      if (out_valid_q & out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         S_FILL: begin
            if (accept) begin
               if (close_word) begin
                  if (slot_free) begin
                     load_out    = 1'b1;
                     load_data   = merged;
                     load_forced = flush_close;
                     asm_d       = '0;
                     cnt_d       = '0;
                  end else begin
                     // Park the complete word until the output slot frees.
                     asm_d       = merged;
                     hold_last_d = flush_close;
                     state_d     = S_HOLD;
                  end
               end else begin
                  asm_d = merged;
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (slot_free) begin
               load_out    = 1'b1;
               load_data   = asm_q;
               load_forced = hold_last_q;
               asm_d       = '0;
               cnt_d       = '0;
               hold_last_d = 1'b0;
               state_d     = S_FILL;
            end
         end
         default: state_d = S_FILL;
      endcase

      if (load_out) begin
         row_end     = (row_q == ROW_MAX) | load_forced;
         out_valid_d = 1'b1;
         out_data_d  = load_data;
         out_last_d  = row_end;
         row_d       = row_end ? '0 : row_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= S_FILL;
         cnt_q       <= '0;
         asm_q       <= '0;
         hold_last_q <= 1'b0;
         row_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         asm_q       <= asm_d;
         hold_last_q <= hold_last_d;
         row_q       <= row_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_pixel_word_packer.sv
// Testbench for pixel_word_packer: directed scenarios plus a randomized
// stream, checked by a scoreboard fed from a pixel-list reference model.

module tb_pixel_word_packer;

   localparam int OW = 128;
   localparam int PW = 8;
   localparam int RW = 4;
   localparam int P  = OW / PW;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst_ni;
   logic          in_valid;
   logic          in_ready;
   logic [PW-1:0] in_pixel;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_data;
   logic          out_last;
   logic          state_o;

   always #5 clk = ~clk;

   pixel_word_packer #(
      .OUTPUT_WIDTH (OW),
      .PIXEL_WIDTH  (PW),
      .ROW_WORDS    (RW)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_ni),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pixel  (in_pixel),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .state_o   (state_o)
   );

   int checks   = 0;
   int failures = 0;
   logic rand_mode = 1'b0;

   // ---------------- reference model ----------------
   logic [PW-1:0] pix_q[$];
   logic [OW:0]   exp_q[$];   // {last, data}
   int            row_cnt = 0;

   task automatic model_accept(input logic [PW-1:0] px, input logic lst);
      logic [OW-1:0] w;
      logic          forced;
      logic          is_last;
      pix_q.push_back(px);
`ifdef PIXEL_PACKER_FLUSH_EN
      forced = lst;
`else
      forced = 1'b0;
`endif
      if (pix_q.size() == P || forced) begin
         w = '0;
         foreach (pix_q[i]) w = w | ({{(OW-PW){1'b0}}, pix_q[i]} << (i * PW));
         is_last = forced || (row_cnt == RW - 1);
         row_cnt = is_last ? 0 : row_cnt + 1;
         exp_q.push_back({is_last, w});
         pix_q.delete();
      end
   endtask

   task automatic model_reset();
      pix_q.delete();
      exp_q.delete();
      row_cnt = 0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic send(input logic [PW-1:0] px, input logic lst);
      int w = 0;
      in_valid = 1'b1;
      in_pixel = px;
      in_last  = lst;
      while (!in_ready) begin
         tick();
         w++;
         if (w > 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stuck low for %0d cycles", w);
            in_valid = 1'b0;
            return;
         end
      end
      model_accept(px, lst);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      rst_ni   = 1'b0;
      model_reset();
      for (int i = 0; i < cycles; i++) tick();
      in_valid = 1'b0;
      rst_ni   = 1'b1;
   endtask

   task automatic drain();
      int w = 0;
      rand_mode = 1'b0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && w < 300) begin
         tick();
         w++;
      end
      check("drain_pending", OW'(exp_q.size()), '0);
   endtask

   // ---------------- scoreboard monitor ----------------
   logic [OW:0] mon_exp;
   logic        stall_seen = 1'b0;
   logic [OW:0] stall_word;

   always @(negedge clk) begin
      if (!rst_ni) begin
         stall_seen = 1'b0;
      end else begin
         if (stall_seen) begin
            checks++;
            if (!out_valid || {out_last, out_data} !== stall_word) begin
               failures++;
               $display("FAIL stall_stable: got valid=%0b word=%h expected valid=1 word=%h",
                        out_valid, {out_last, out_data}, stall_word);
            end
         end
         stall_seen = out_valid && !out_ready;
         stall_word = {out_last, out_data};
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL word_unexpected: got last=%0b data=%h expected no word",
                        out_last, out_data);
            end else begin
               mon_exp = exp_q.pop_front();
               if ({out_last, out_data} !== mon_exp) begin
                  failures++;
                  $display("FAIL word: got last=%0b data=%h expected last=%0b data=%h",
                           out_last, out_data, mon_exp[OW], mon_exp[OW-1:0]);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int acc;
      logic [PW-1:0] px;
      rst_ni    = 1'b0;
      in_valid  = 1'b1;
      in_pixel  = 8'h55;
      in_last   = 1'b0;
      out_ready = 1'b1;

      // Reset held 3 clocks with in_valid high.
      for (int i = 0; i < 3; i++) tick();
      check("rst_out_valid", OW'(out_valid), '0);
      check("rst_out_data", out_data, '0);
      check("rst_out_last", OW'(out_last), '0);
      in_valid = 1'b0;
      rst_ni   = 1'b1;
      tick();
      check("rst_in_ready", OW'(in_ready), OW'(1));
      check("rst_idle_valid", OW'(out_valid), '0);

      // One word, out_ready high: word visible the cycle after pixel 16.
      for (int i = 1; i <= 16; i++) send(PW'(i), 1'b0);
      check("lat_valid", OW'(out_valid), OW'(1));
      check("lat_data", out_data, 128'h100F0E0D0C0B0A090807060504030201);
      tick();
      check("lat_one_cycle", OW'(out_valid), '0);

      // Backpressure: 32 pixels fit (output + assembly) before in_ready drops.
      out_ready = 1'b0;
      acc = 0;
      in_valid = 1'b1;
      while (in_ready && acc < 40) begin
         in_pixel = PW'(acc + 1);
         model_accept(in_pixel, 1'b0);
         acc++;
         tick();
      end
      in_valid = 1'b0;
      check("bp_accepts", OW'(acc), OW'(32));
      check("bp_ready_low", OW'(in_ready), '0);
      out_ready = 1'b1;
      tick();
      check("bp_ready_back", OW'(in_ready), OW'(1));
      check("bp_second_word", OW'(out_valid), OW'(1));
      drain();

      // Reset mid-word discards the partial assembly.
      for (int i = 0; i < 7; i++) send(PW'(8'h30 + i), 1'b0);
      do_reset(1);
      for (int i = 0; i < 16; i++) send(PW'(8'hA0 + i), 1'b0);
      check("rst_mid_data", out_data, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
      check("rst_mid_last", OW'(out_last), '0);
      drain();

      // Row tagging: 128 pixels from a fresh row -> last on words 4 and 8.
      do_reset(1);
      for (int i = 0; i < 128; i++) send(PW'($urandom_range(0, 255)), 1'b0);
      drain();

`ifdef PIXEL_PACKER_FLUSH_EN
      // Early close on in_last.
      for (int i = 0; i < 5; i++) send(PW'(8'h11 + i), (i == 4));
      check("flush_valid", OW'(out_valid), OW'(1));
      check("flush_data", out_data, 128'h1514131211);
      check("flush_last", OW'(out_last), OW'(1));
      drain();
`endif

      // Randomized stream with random gaps and random consumer stalls.
      rand_mode = 1'b1;
      for (int i = 0; i < 600; i++) begin
         for (int g = $urandom_range(0, 3); g > 2; g--) tick();
         px = PW'($urandom_range(0, 255));
         send(px, ($urandom_range(0, 19) == 0));
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
